rv_multicycle_ctrl: RTL and testbench

- Multicycle FSM controller that sequences the shared RV32I datapath: one ALU and one unified instruction/data memory, with architectural PC, IR, OldPC, Data, A and WriteData registers living in the datapath.
- Supports lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq and jal.
- Adds a memory ready handshake, a sticky trap on unsupported opcodes, and a retired-instruction counter.

---
 rtl/rv_ctrl_pkg.sv | 69 ++++++
 rtl/rv_alu_dec.sv | 39 +++
 rtl/rv_multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg
// Shared definitions for the RV32I multicycle controller:
//   - statetype_t : FSM state encoding (4 bits, FETCH = 0 ... TRAP = 11)
//   - OP_*        : the opcodes the controller recognises
//   - ALU control, ALUOp and datapath mux-select constants
//   - imm_src()   : immediate-format decode from the opcode
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } statetype_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format is a pure function of the opcode; loads, ALU
    // immediates and anything unrecognised all use the I-type layout.
    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/rv_alu_dec.sv
// rv_alu_dec
// Combinational ALU decoder.
// Ports:
//   alu_op      in  2  00 add, 01 sub, 10 decode from funct fields
//   funct3      in  3  Instr[14:12]
//   op5         in  1  Instr[5], separates R-type from I-type
//   funct7b5    in  1  Instr[30]
//   alu_control out 3  ALU operation select
module rv_alu_dec
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    // Subtract only for R-type with funct7[5] set; for addi bit 30 is
    // just immediate data, so op5 must qualify it.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
// Multicycle FSM controller for a shared-ALU, unified-memory RV32I datapath.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   i_Op/i_Funct3/i_Funct7b5  instruction fields from IR
//   i_Zero, i_MemReady    ALU zero flag, memory access completes this cycle
//   o_MemReq/o_MemWrite/o_AdrSrc  memory request, store strobe, address mux
//   o_IRWrite/o_PCWrite/o_RegWrite  architectural register write enables
//   o_ResultSrc/o_ALUSrcA/o_ALUSrcB/o_ImmSrc/o_ALUControl  datapath selects
//   o_Retire/o_Retired    completion pulse and retired-instruction count
//   o_Trap                sticky illegal-opcode flag
module rv_multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       i_Op,
    input  logic [2:0]       i_Funct3,
    input  logic             i_Funct7b5,
    input  logic             i_Zero,
    input  logic             i_MemReady,
    output logic             o_MemReq,
    output logic             o_AdrSrc,
    output logic             o_MemWrite,
    output logic             o_IRWrite,
    output logic             o_PCWrite,
    output logic             o_RegWrite,
    output logic [1:0]       o_ResultSrc,
    output logic [1:0]       o_ALUSrcA,
    output logic [1:0]       o_ALUSrcB,
    output logic [1:0]       o_ImmSrc,
    output logic [2:0]       o_ALUControl,
    output logic             o_Retire,
    output logic [CNT_W-1:0] o_Retired,
    output logic             o_Trap
);

    statetype_t       state_q, state_d;
    logic [1:0]       alu_op;
    logic             mem_req, mem_write, ir_write, pc_write, reg_write;
    logic             retire, trap;
    logic [CNT_W-1:0] retired_q;

    // State register; reset drops any in-flight instruction back to FETCH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic. Memory states hold until the access completes;
    // TRAP is absorbing and only reset leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:    if (i_MemReady) state_d = DECODE;
            DECODE: begin
                case (i_Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_BEQ:       state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = i_Op[5] ? MEMWRITE : MEMREAD;
            MEMREAD:  if (i_MemReady) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (i_MemReady) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BEQ:      state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase
    end

    // Per-state output decode. Mux selects are Moore; only the PC/IR write
    // enables and the retire pulse look at MemReady or Zero.
    always_comb begin
        mem_req     = 1'b0;
        o_AdrSrc    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        retire      = 1'b0;
        trap        = 1'b0;
        o_ResultSrc = RES_ALUOUT;
        o_ALUSrcA   = SRCA_PC;
        o_ALUSrcB   = SRCB_WD;
        alu_op      = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req     = 1'b1;
                o_ALUSrcB   = SRCB_FOUR;
                o_ResultSrc = RES_ALURESULT;
                ir_write    = i_MemReady;
                pc_write    = i_MemReady;
            end
            DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req  = 1'b1;
                o_AdrSrc = 1'b1;
            end
            MEMWB: begin
                o_ResultSrc = RES_DATA;
                reg_write   = 1'b1;
                retire      = 1'b1;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                o_AdrSrc  = 1'b1;
                retire    = i_MemReady;
            end
            EXECUTER: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_WD;
                alu_op    = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            BEQ: begin
                o_ALUSrcA = SRCA_A;
                o_ALUSrcB = SRCB_WD;
                alu_op    = ALUOP_SUB;
                pc_write  = i_Zero;
                retire    = 1'b1;
            end
            JAL: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_FOUR;
                pc_write  = 1'b1;
            end
            TRAP:    trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

    // Strobes are forced low for as long as reset is held, even though the
    // FETCH state itself would otherwise request memory.
    always_comb begin
        o_MemReq   = mem_req   & ~reset;
        o_MemWrite = mem_write & ~reset;
        o_IRWrite  = ir_write  & ~reset;
        o_PCWrite  = pc_write  & ~reset;
        o_RegWrite = reg_write & ~reset;
        o_Retire   = retire    & ~reset;
        o_Trap     = trap      & ~reset;
        o_ImmSrc   = imm_src(i_Op);
    end

    rv_alu_dec u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (i_Funct3),
        .op5         (i_Op[5]),
        .funct7b5    (i_Funct7b5),
        .alu_control (o_ALUControl)
    );

    // Retired-instruction counter, wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         retired_q <= '0;
        else if (o_Retire) retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign o_Retired = retired_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl
// Scoreboard bench for rv_multicycle_ctrl. The stimulus process walks each
// instruction through the cycle sequence its class implies, driving inputs
// and queuing the expected control bundle and retire count for every cycle;
// a monitor on the falling edge pops and compares.
module tb_rv_multicycle_ctrl;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    logic        clk;
    logic        reset;
    logic [6:0]  i_Op;
    logic [2:0]  i_Funct3;
    logic        i_Funct7b5;
    logic        i_Zero;
    logic        i_MemReady;
    logic        o_MemReq, o_AdrSrc, o_MemWrite, o_IRWrite, o_PCWrite, o_RegWrite;
    logic [1:0]  o_ResultSrc, o_ALUSrcA, o_ALUSrcB, o_ImmSrc;
    logic [2:0]  o_ALUControl;
    logic        o_Retire, o_Trap;
    logic [31:0] o_Retired;

    rv_multicycle_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_Op         (i_Op),
        .i_Funct3     (i_Funct3),
        .i_Funct7b5   (i_Funct7b5),
        .i_Zero       (i_Zero),
        .i_MemReady   (i_MemReady),
        .o_MemReq     (o_MemReq),
        .o_AdrSrc     (o_AdrSrc),
        .o_MemWrite   (o_MemWrite),
        .o_IRWrite    (o_IRWrite),
        .o_PCWrite    (o_PCWrite),
        .o_RegWrite   (o_RegWrite),
        .o_ResultSrc  (o_ResultSrc),
        .o_ALUSrcA    (o_ALUSrcA),
        .o_ALUSrcB    (o_ALUSrcB),
        .o_ImmSrc     (o_ImmSrc),
        .o_ALUControl (o_ALUControl),
        .o_Retire     (o_Retire),
        .o_Retired    (o_Retired),
        .o_Trap       (o_Trap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [18:0] v;
        logic [31:0] cnt;
    } exp_t;

    exp_t        q[$];
    int unsigned modelCnt;
    int          nVec;
    int          nMis;

    wire [18:0] dutVec = {o_MemReq, o_AdrSrc, o_MemWrite, o_IRWrite, o_PCWrite,
                          o_RegWrite, o_ResultSrc, o_ALUSrcA, o_ALUSrcB,
                          o_ImmSrc, o_ALUControl, o_Retire, o_Trap};

    // Control bundle packing: strobes, selects, ImmSrc, ALUControl, Retire, Trap.
    function automatic logic [18:0] vec(input logic mr, input logic as,
        input logic mw, input logic irw, input logic pcw, input logic rw,
        input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
        input logic [1:0] imm, input logic [2:0] alu, input logic ret,
        input logic tr);
        vec = {mr, as, mw, irw, pcw, rw, rs, sa, sb, imm, alu, ret, tr};
    endfunction

    function automatic logic [1:0] immOf(input logic [6:0] op);
        if (op == SW)      immOf = 2'b01;
        else if (op == BR) immOf = 2'b10;
        else if (op == JL) immOf = 2'b11;
        else               immOf = 2'b00;
    endfunction

    // ALU operation an R/I-type instruction asks for, read off its fields.
    function automatic logic [2:0] aluOf(input logic [31:0] ir);
        logic [2:0] f3;
        f3 = ir[14:12];
        if (f3 == 3'b000)      aluOf = (ir[5] && ir[30]) ? 3'b001 : 3'b000;
        else if (f3 == 3'b010) aluOf = 3'b101;
        else if (f3 == 3'b110) aluOf = 3'b011;
        else if (f3 == 3'b111) aluOf = 3'b010;
        else                   aluOf = 3'b000;
    endfunction

    function automatic logic rnd();
        rnd = 1'($urandom_range(0, 1));
    endfunction

    // One clock of stimulus: drive inputs, queue what that cycle must show.
    task automatic step(input logic rdy, input logic z, input logic [18:0] v);
        i_MemReady = rdy;
        i_Zero     = z;
        q.push_back({v, modelCnt});
        if (v[1]) modelCnt++;
        @(posedge clk);
        #1;
    endtask

    // Reset for one cycle; optionally raised mid-cycle to exercise the
    // asynchronous path.
    task automatic doReset(input bit mid);
        if (mid) #1;
        reset    = 1'b1;
        modelCnt = 0;
        q.push_back({vec(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, immOf(i_Op),
                         3'b000, 0, 0), 32'd0});
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Run one instruction: fw fetch wait states, mw data-memory wait states,
    // z the branch compare result, abort to reset during the load access.
    task automatic applyStimulus(input logic [31:0] ir, input int fw,
        input int mw, input logic z, input bit abort);
        logic [6:0] op;
        logic [1:0] im;
        logic [2:0] alu;
        op         = ir[6:0];
        im         = immOf(op);
        alu        = aluOf(ir);
        i_Op       = op;
        i_Funct3   = ir[14:12];
        i_Funct7b5 = ir[30];
        for (int k = 0; k < fw; k++)
            step(0, rnd(), vec(1, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0));
        step(1, rnd(), vec(1, 0, 0, 1, 1, 0, 2'b10, 2'b00, 2'b10, im, 3'b000, 0, 0));
        step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, im, 3'b000, 0, 0));
        if (op == LW || op == SW) begin
            step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, im, 3'b000, 0, 0));
            if (op == LW) begin
                for (int k = 0; k < mw; k++)
                    step(0, rnd(), vec(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
                if (abort) begin
                    doReset(1);
                    return;
                end
                step(1, rnd(), vec(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
                step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, im, 3'b000, 1, 0));
            end else begin
                for (int k = 0; k < mw; k++)
                    step(0, rnd(), vec(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 0));
                step(1, rnd(), vec(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
            end
        end else if (op == RT || op == IT) begin
            step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b10,
                                   (op == IT) ? 2'b01 : 2'b00, im, alu, 0, 0));
            step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
        end else if (op == BR) begin
            step(rnd(), z, vec(0, 0, 0, 0, z, 0, 2'b00, 2'b10, 2'b00, im, 3'b001, 1, 0));
        end else if (op == JL) begin
            step(rnd(), rnd(), vec(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, im, 3'b000, 0, 0));
            step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, im, 3'b000, 1, 0));
        end else begin
            for (int k = 0; k < 20; k++)
                step(rnd(), rnd(), vec(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, im, 3'b000, 0, 1));
            doReset(1);
        end
    endtask

    // Monitor: every queued cycle is compared on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checkOutput("ctrl", {13'd0, dutVec}, {13'd0, e.v});
            checkOutput("retired", o_Retired, e.cnt);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got,
        input logic [31:0] want);
        nVec++;
        if (got !== want) begin
            nMis++;
            $display("[TB] FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    function automatic logic [31:0] randInstr();
        logic [31:0] ir;
        logic [2:0]  f3s [4];
        f3s = '{3'b000, 3'b010, 3'b110, 3'b111};
        ir = $urandom;
        case ($urandom_range(0, 6))
            0: ir[6:0] = LW;
            1: ir[6:0] = SW;
            2: begin ir[6:0] = RT; ir[14:12] = f3s[$urandom_range(0, 3)]; end
            3: ir[6:0] = IT;
            4: ir[6:0] = BR;
            5: ir[6:0] = JL;
            default: ir[6:0] = 7'($urandom);
        endcase
        randInstr = ir;
    endfunction

    initial begin
        nVec       = 0;
        nMis       = 0;
        modelCnt   = 0;
        reset      = 1'b1;
        i_Op       = 7'd0;
        i_Funct3   = 3'd0;
        i_Funct7b5 = 1'b0;
        i_Zero     = 1'b0;
        i_MemReady = 1'b0;
        @(posedge clk);
        #1;
        doReset(0);

        applyStimulus(32'hFFC4A303, 0, 0, 0, 0);
        applyStimulus(32'h0064A423, 0, 3, 0, 0);
        applyStimulus(32'h40520233, 0, 0, 0, 0);
        applyStimulus(32'h00520233, 0, 0, 0, 0);
        applyStimulus(32'h00420463, 0, 0, 1, 0);
        applyStimulus(32'h00420463, 0, 0, 0, 0);
        applyStimulus(32'h008000EF, 1, 0, 0, 0);
        applyStimulus(32'h40A30313, 0, 0, 0, 0);
        applyStimulus(32'h00000073, 0, 0, 0, 0);
        applyStimulus(32'h00000000, 0, 0, 0, 0);
        applyStimulus(32'h00A37333, 2, 0, 0, 0);
        applyStimulus(32'hFFC4A303, 1, 2, 0, 1);
        applyStimulus(32'h0062A303, 0, 1, 0, 0);

        for (int n = 0; n < 150; n++)
            applyStimulus(randInstr(), $urandom_range(0, 3), $urandom_range(0, 3),
                          rnd(), ($urandom_range(0, 15) == 0));

        repeat (2) @(negedge clk);
        checkOutput("drain", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
